ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline; sits directly downstream of the decode stage and upstream of the memory stage.
- Registers the decode-to-execute bus and computes the ALU result.
- Issues the data-SRAM request and drives the forwarding and load-use signals back to decode.
- Owns the HI/LO registers: single-cycle MULT/MULTU, a 32-iteration restoring divider for DIV/DIVU with stall request, and MFHI/MFLO/MTHI/MTLO.

---
 rtl/ex_stage.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
// Holds the decode-to-execute register, computes the ALU result, issues the
// data-SRAM request, drives forwarding/load-use info back to decode and owns
// HI/LO together with the MULT/MULTU unit and a restoring divider.
module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    ex_wreg,
    output logic [4:0]              ex_waddr,
    output logic [31:0]             ex_wdata,
    output logic                    ex_opl,
    output logic                    stallreq_for_ex
);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Two's-complement magnitude of a 32-bit value (INT_MIN maps to 2^31).
    function automatic logic [31:0] abs32(input logic [31:0] v);
        abs32 = v[31] ? (~v + 32'd1) : v;
    endfunction

    logic [ID_TO_EX_WD-1:0] r_id_to_ex;

    // Decode-to-execute register: reset, bubble, load or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_to_ex <= '0;
        end else if (stall[2] && !stall[3]) begin
            r_id_to_ex <= '0;
        end else if (!stall[2]) begin
            r_id_to_ex <= id_to_ex_bus;
        end else begin
            r_id_to_ex <= r_id_to_ex;
        end
    end

    logic [31:0] w_pc, w_inst, w_rdata1, w_rdata2;
    logic [11:0] w_alu_op;
    logic [2:0]  w_sel_src1;
    logic [3:0]  w_sel_src2;
    logic        w_ram_en, w_rf_we, w_sel_rf_res;
    logic [3:0]  w_ram_wen;
    logic [4:0]  w_rf_waddr;

    assign w_pc         = r_id_to_ex[158:127];
    assign w_inst       = r_id_to_ex[126:95];
    assign w_alu_op     = r_id_to_ex[94:83];
    assign w_sel_src1   = r_id_to_ex[82:80];
    assign w_sel_src2   = r_id_to_ex[79:76];
    assign w_ram_en     = r_id_to_ex[75];
    assign w_ram_wen    = r_id_to_ex[74:71];
    assign w_rf_we      = r_id_to_ex[70];
    assign w_rf_waddr   = r_id_to_ex[69:65];
    assign w_sel_rf_res = r_id_to_ex[64];
    assign w_rdata1     = r_id_to_ex[63:32];
    assign w_rdata2     = r_id_to_ex[31:0];

    // ------------------------------------------------------------------ ALU
    logic [31:0] w_op1, w_op2;
    logic [4:0]  w_sa;
    logic [31:0] w_add, w_sub, w_slt, w_sltu, w_and, w_nor, w_or, w_xor;
    logic [31:0] w_sll, w_srl, w_sra, w_lui, w_alu_result;

    assign w_op1 = ({32{w_sel_src1[0]}} & w_rdata1)
                 | ({32{w_sel_src1[1]}} & w_pc)
                 | ({32{w_sel_src1[2]}} & {27'd0, w_inst[10:6]});
    assign w_op2 = ({32{w_sel_src2[0]}} & w_rdata2)
                 | ({32{w_sel_src2[1]}} & {{16{w_inst[15]}}, w_inst[15:0]})
                 | ({32{w_sel_src2[2]}} & 32'd8)
                 | ({32{w_sel_src2[3]}} & {16'd0, w_inst[15:0]});
    assign w_sa   = w_op1[4:0];
    assign w_add  = w_op1 + w_op2;
    assign w_sub  = w_op1 - w_op2;
    assign w_slt  = {31'd0, ($signed(w_op1) < $signed(w_op2))};
    assign w_sltu = {31'd0, (w_op1 < w_op2)};
    assign w_and  = w_op1 & w_op2;
    assign w_nor  = ~(w_op1 | w_op2);
    assign w_or   = w_op1 | w_op2;
    assign w_xor  = w_op1 ^ w_op2;
    assign w_sll  = w_op2 << w_sa;
    assign w_srl  = w_op2 >> w_sa;
    assign w_sra  = $signed(w_op2) >>> w_sa;
    assign w_lui  = {w_op2[15:0], 16'h0000};

    assign w_alu_result = ({32{w_alu_op[0]}}  & w_add)  | ({32{w_alu_op[1]}}  & w_sub)
                        | ({32{w_alu_op[2]}}  & w_slt)  | ({32{w_alu_op[3]}}  & w_sltu)
                        | ({32{w_alu_op[4]}}  & w_and)  | ({32{w_alu_op[5]}}  & w_nor)
                        | ({32{w_alu_op[6]}}  & w_or)   | ({32{w_alu_op[7]}}  & w_xor)
                        | ({32{w_alu_op[8]}}  & w_sll)  | ({32{w_alu_op[9]}}  & w_srl)
                        | ({32{w_alu_op[10]}} & w_sra)  | ({32{w_alu_op[11]}} & w_lui);

    // ------------------------------------------------- HI/LO special decode
    logic w_special, w_is_mult, w_is_multu, w_is_div, w_is_divu;
    logic w_is_mfhi, w_is_mflo, w_is_mthi, w_is_mtlo, w_is_div_any;

    assign w_special    = (w_inst[31:26] == 6'b000000);
    assign w_is_mult    = w_special && (w_inst[5:0] == 6'b011000);
    assign w_is_multu   = w_special && (w_inst[5:0] == 6'b011001);
    assign w_is_div     = w_special && (w_inst[5:0] == 6'b011010);
    assign w_is_divu    = w_special && (w_inst[5:0] == 6'b011011);
    assign w_is_mfhi    = w_special && (w_inst[5:0] == 6'b010000);
    assign w_is_mthi    = w_special && (w_inst[5:0] == 6'b010001);
    assign w_is_mflo    = w_special && (w_inst[5:0] == 6'b010010);
    assign w_is_mtlo    = w_special && (w_inst[5:0] == 6'b010011);
    assign w_is_div_any = w_is_div | w_is_divu;

    logic [63:0] w_prod_s, w_prod_u;
    assign w_prod_s = $signed({{32{w_rdata1[31]}}, w_rdata1}) * $signed({{32{w_rdata2[31]}}, w_rdata2});
    assign w_prod_u = {32'd0, w_rdata1} * {32'd0, w_rdata2};

    // -------------------------------------------------------------- divider
    div_state_t  r_div_state, w_div_next;
    logic [4:0]  r_div_cnt;
    logic [31:0] r_div_rem, r_div_quo, r_div_dsr;
    logic        r_neg_q, r_neg_r, r_dsr_zero;
    logic        w_stallreq;

    // Divider next-state and stall request.
    always_comb begin
        w_div_next = r_div_state;
        w_stallreq = 1'b0;
        case (r_div_state)
            DIV_IDLE: begin
                if (w_is_div_any) begin
                    w_div_next = DIV_RUN;
                    w_stallreq = 1'b1;
                end else begin
                    w_div_next = DIV_IDLE;
                end
            end
            DIV_RUN: begin
                w_stallreq = 1'b1;
                if (r_div_cnt == 5'd31) begin
                    w_div_next = DIV_DONE;
                end else begin
                    w_div_next = DIV_RUN;
                end
            end
            DIV_DONE: begin
                if (!stall[2]) begin
                    w_div_next = DIV_IDLE;
                end else begin
                    w_div_next = DIV_DONE;
                end
            end
            default: begin
                w_div_next = DIV_IDLE;
            end
        endcase
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_state <= DIV_IDLE;
        end else begin
            r_div_state <= w_div_next;
        end
    end

    // One restoring step: shift the next dividend bit into the partial remainder.
    logic [32:0] w_shift, w_diff;
    logic        w_ge;
    logic [31:0] w_rem_next, w_quo_next;
    assign w_shift    = {r_div_rem, r_div_quo[31]};
    assign w_ge       = (w_shift >= {1'b0, r_div_dsr});
    assign w_diff     = w_shift - {1'b0, r_div_dsr};
    assign w_rem_next = w_ge ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_next = {r_div_quo[30:0], w_ge};

    // Divider datapath: capture magnitudes in IDLE, iterate in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt  <= 5'd0;
            r_div_rem  <= 32'd0;
            r_div_quo  <= 32'd0;
            r_div_dsr  <= 32'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dsr_zero <= 1'b0;
        end else begin
            case (r_div_state)
                DIV_IDLE: begin
                    if (w_is_div_any) begin
                        r_div_cnt  <= 5'd0;
                        r_div_rem  <= 32'd0;
                        r_div_quo  <= w_is_div ? abs32(w_rdata1) : w_rdata1;
                        r_div_dsr  <= w_is_div ? abs32(w_rdata2) : w_rdata2;
                        r_neg_q    <= w_is_div & (w_rdata1[31] ^ w_rdata2[31]);
                        r_neg_r    <= w_is_div & w_rdata1[31];
                        r_dsr_zero <= (w_rdata2 == 32'd0);
                    end else begin
                        r_div_cnt  <= r_div_cnt;
                    end
                end
                DIV_RUN: begin
                    r_div_cnt <= r_div_cnt + 5'd1;
                    r_div_rem <= w_rem_next;
                    r_div_quo <= w_quo_next;
                end
                default: begin
                    r_div_cnt <= r_div_cnt;
                end
            endcase
        end
    end

    // Divide-by-zero keeps the all-ones quotient; the remainder then equals rs.
    logic [31:0] w_div_quot, w_div_rem;
    assign w_div_quot = (r_neg_q && !r_dsr_zero) ? (~r_div_quo + 32'd1) : r_div_quo;
    assign w_div_rem  = r_neg_r ? (~r_div_rem + 32'd1) : r_div_rem;

    // ---------------------------------------------------------------- HI/LO
    logic [31:0] r_hi, r_lo;

    // HI/LO update; only when EX advances this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (stall[2]) begin
            r_hi <= r_hi;
        end else if (r_div_state == DIV_DONE) begin
            r_lo <= w_div_quot;
            r_hi <= w_div_rem;
        end else if (r_div_state != DIV_IDLE) begin
            r_hi <= r_hi;
        end else if (w_is_mult) begin
            {r_hi, r_lo} <= w_prod_s;
        end else if (w_is_multu) begin
            {r_hi, r_lo} <= w_prod_u;
        end else if (w_is_mthi) begin
            r_hi <= w_rdata1;
        end else if (w_is_mtlo) begin
            r_lo <= w_rdata1;
        end else begin
            r_hi <= r_hi;
        end
    end

    // ------------------------------------------------------------- outputs
    logic [31:0] w_ex_result;
    logic        w_eff_we;
    logic [4:0]  w_eff_waddr;

    // Effective write-back value, enable and destination.
    always_comb begin
        w_ex_result = w_alu_result;
        w_eff_we    = w_rf_we;
        w_eff_waddr = w_rf_waddr;
        if (w_is_mfhi) begin
            w_ex_result = r_hi;
            w_eff_we    = 1'b1;
            w_eff_waddr = w_inst[15:11];
        end else if (w_is_mflo) begin
            w_ex_result = r_lo;
            w_eff_we    = 1'b1;
            w_eff_waddr = w_inst[15:11];
        end else if (w_is_div_any) begin
            w_ex_result = 32'd0;
            w_eff_we    = 1'b0;
        end else if (w_is_mult || w_is_multu || w_is_mthi || w_is_mtlo) begin
            w_eff_we    = 1'b0;
        end else begin
            w_ex_result = w_alu_result;
        end
    end

    assign ex_to_mem_bus   = {w_pc, w_ram_en, w_ram_wen, w_sel_rf_res, w_eff_we, w_eff_waddr, w_ex_result};
    assign data_sram_en    = w_ram_en;
    assign data_sram_wen   = w_ram_wen;
    assign data_sram_addr  = w_alu_result;
    assign data_sram_wdata = w_rdata2;
    assign ex_wreg         = w_eff_we;
    assign ex_waddr        = w_eff_waddr;
    assign ex_wdata        = w_ex_result;
    assign ex_opl          = w_sel_rf_res & w_rf_we;
    assign stallreq_for_ex = w_stallreq;

    // Stall bits owned by other stages and instruction fields not decoded here.
    logic w_unused;
    assign w_unused = ^{stall[STALL_WD-1:4], stall[1:0], w_inst[25:16], w_diff[32]};

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus random instructions
// compared with a behavioural model of the execute stage and HI/LO.
module tb_ex_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel1;
        logic [3:0]  sel2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  waddr;
        logic        sel_rf_res;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } instr_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic         data_sram_en, ex_wreg, ex_opl, stallreq_for_ex;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata, ex_wdata;
    logic [4:0]   ex_waddr;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
        .ex_to_mem_bus(ex_to_mem_bus), .data_sram_en(data_sram_en),
        .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .ex_wreg(ex_wreg), .ex_waddr(ex_waddr),
        .ex_wdata(ex_wdata), .ex_opl(ex_opl), .stallreq_for_ex(stallreq_for_ex)
    );

    task automatic check_val(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input logic [158:0] b, input logic [5:0] s);
        @(negedge clk);
        id_to_ex_bus = b;
        stall        = s;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_alu(input instr_t t);
        logic [31:0] a, b, r, sra_v;
        logic signed [31:0] sb;
        int sh;
        case (t.sel1)
            3'b001:  a = t.rd1;
            3'b010:  a = t.pc;
            3'b100:  a = {27'd0, t.inst[10:6]};
            default: a = 32'd0;
        endcase
        case (t.sel2)
            4'b0001: b = t.rd2;
            4'b0010: b = 32'($signed(t.inst[15:0]));
            4'b0100: b = 32'd8;
            4'b1000: b = {16'd0, t.inst[15:0]};
            default: b = 32'd0;
        endcase
        sh    = int'(a[4:0]);
        sb    = b;
        sra_v = sb >>> sh;
        r     = 32'd0;
        for (int k = 0; k < 12; k++) begin
            if (t.alu_op[k]) begin
                case (k)
                    0:  r |= a + b;
                    1:  r |= a - b;
                    2:  r |= ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3:  r |= (a < b) ? 32'd1 : 32'd0;
                    4:  r |= a & b;
                    5:  r |= ~(a | b);
                    6:  r |= a | b;
                    7:  r |= a ^ b;
                    8:  r |= b << sh;
                    9:  r |= b >> sh;
                    10: r |= sra_v;
                    default: r |= {b[15:0], 16'h0000};
                endcase
            end
        end
        return r;
    endfunction

    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output logic [31:0] q, output logic [31:0] r);
        longint la, lb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            lq = la / lb;
            lr = la % lb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
    endtask

    // Issue one instruction with the pipeline flowing, check EX outputs,
    // follow a divide through its stall window, then update the HI/LO model.
    task automatic run_instr(input instr_t t);
        logic sp, mfh, mfl, mth, mtl, mul, mulu, dv, dvu, we;
        logic [5:0]  fn;
        logic [4:0]  wa;
        logic [31:0] alu, res, q, r;
        logic [63:0] p;
        int cyc;
        sp   = (t.inst[31:26] == 6'd0);
        fn   = t.inst[5:0];
        mfh  = sp && fn == 6'b010000;
        mth  = sp && fn == 6'b010001;
        mfl  = sp && fn == 6'b010010;
        mtl  = sp && fn == 6'b010011;
        mul  = sp && fn == 6'b011000;
        mulu = sp && fn == 6'b011001;
        dv   = sp && fn == 6'b011010;
        dvu  = sp && fn == 6'b011011;
        alu  = ref_alu(t);
        res  = mfh ? m_hi : mfl ? m_lo : (dv | dvu) ? 32'd0 : alu;
        we   = (mfh | mfl) ? 1'b1 : (mul | mulu | dv | dvu | mth | mtl) ? 1'b0 : t.rf_we;
        wa   = (mfh | mfl) ? t.inst[15:11] : t.waddr;
        step(t, 6'd0);
        check_val("ex_to_mem_bus", ex_to_mem_bus, {t.pc, t.ram_en, t.ram_wen, t.sel_rf_res, we, wa, res});
        check_val("sram_en", 76'(data_sram_en), 76'(t.ram_en));
        check_val("sram_wen", 76'(data_sram_wen), 76'(t.ram_wen));
        check_val("sram_addr", 76'(data_sram_addr), 76'(alu));
        check_val("sram_wdata", 76'(data_sram_wdata), 76'(t.rd2));
        check_val("ex_wreg", 76'(ex_wreg), 76'(we));
        check_val("ex_waddr", 76'(ex_waddr), 76'(wa));
        check_val("ex_wdata", 76'(ex_wdata), 76'(res));
        check_val("ex_opl", 76'(ex_opl), 76'(t.sel_rf_res & t.rf_we));
        check_val("stallreq", 76'(stallreq_for_ex), 76'(dv | dvu));
        if (dv | dvu) begin
            cyc = 0;
            while (stallreq_for_ex === 1'b1 && cyc < 100) begin
                cyc++;
                step(t, 6'b001111);
            end
            check_val("div_stall_cycles", 76'(cyc), 76'(33));
            ref_div(t.rd1, t.rd2, dv, q, r);
            m_lo = q;
            m_hi = r;
        end
        if (mul) begin
            p = 64'(longint'($signed(t.rd1)) * longint'($signed(t.rd2)));
            {m_hi, m_lo} = p;
        end
        if (mulu) begin
            p = {32'd0, t.rd1} * {32'd0, t.rd2};
            {m_hi, m_lo} = p;
        end
        if (mth) m_hi = t.rd1;
        if (mtl) m_lo = t.rd1;
    endtask

    function automatic instr_t mk_special(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        instr_t t;
        t       = '0;
        t.pc    = $urandom;
        t.inst  = {6'd0, 5'd4, 5'd5, 5'($urandom_range(1, 31)), 5'd0, fn};
        t.sel1  = 3'b001;
        t.sel2  = 4'b0001;
        t.rf_we = 1'($urandom_range(0, 1));
        t.waddr = 5'($urandom);
        t.rd1   = a;
        t.rd2   = b;
        return t;
    endfunction

    function automatic instr_t mk_alu(input logic [31:0] inst, input logic [11:0] op, input logic [2:0] s1,
                                      input logic [3:0] s2, input logic [31:0] a, input logic [31:0] b);
        instr_t t;
        t        = '0;
        t.pc     = 32'hBFC0_0000 + 32'($urandom_range(0, 4095) * 4);
        t.inst   = inst;
        t.alu_op = op;
        t.sel1   = s1;
        t.sel2   = s2;
        t.rf_we  = 1'b1;
        t.waddr  = 5'($urandom_range(1, 31));
        t.rd1    = a;
        t.rd2    = b;
        return t;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h80000000;
            1:       return 32'h7FFFFFFF;
            2:       return 32'hFFFFFFFF;
            3:       return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        instr_t t;
        logic [31:0] inst;
        rst = 1'b1;
        stall = 6'd0;
        id_to_ex_bus = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_bus", ex_to_mem_bus, 76'd0);
        check_val("reset_stallreq", 76'(stallreq_for_ex), 76'd0);
        check_val("reset_sram_en", 76'(data_sram_en), 76'd0);
        @(negedge clk);
        rst = 1'b0;

        // ADDIU overflow wraps, written back
        t = mk_alu({6'b001001, 5'd1, 5'd2, 16'h0001}, 12'h001, 3'b001, 4'b0010, 32'h7FFFFFFF, 32'd0);
        run_instr(t);
        check_val("addiu_value", 76'(ex_wdata), 76'(32'h80000000));
        check_val("addiu_wreg", 76'(ex_wreg), 76'd1);
        // SRA by inst sa=4
        t = mk_alu({6'd0, 5'd0, 5'd2, 5'd3, 5'd4, 6'b000011}, 12'h400, 3'b100, 4'b0001, 32'd0, 32'hF0000000);
        run_instr(t);
        check_val("sra_value", 76'(ex_wdata), 76'(32'hFF000000));
        // SLT / SLTU of -1 vs 1
        t = mk_alu({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b101010}, 12'h004, 3'b001, 4'b0001, 32'hFFFFFFFF, 32'd1);
        run_instr(t);
        check_val("slt_value", 76'(ex_wdata), 76'd1);
        t.alu_op = 12'h008;
        run_instr(t);
        check_val("sltu_value", 76'(ex_wdata), 76'd0);
        // LW then a bubble while stall[2]=1, stall[3]=0
        t = mk_alu({6'b100011, 5'd1, 5'd2, 16'hFFFC}, 12'h001, 3'b001, 4'b0010, 32'h0000_1000, 32'h1234_5678);
        t.ram_en = 1'b1;
        t.sel_rf_res = 1'b1;
        run_instr(t);
        check_val("lw_opl", 76'(ex_opl), 76'd1);
        check_val("lw_addr", 76'(data_sram_addr), 76'(32'h0000_0FFC));
        step(t, 6'b000100);
        check_val("bubble_bus", ex_to_mem_bus, 76'd0);
        check_val("bubble_en", 76'(data_sram_en), 76'd0);
        check_val("bubble_wen", 76'(data_sram_wen), 76'd0);
        check_val("bubble_opl", 76'(ex_opl), 76'd0);
        // DIV -7 / 2, then read back through MFLO/MFHI
        run_instr(mk_special(6'b011010, 32'hFFFFFFF9, 32'd2));
        run_instr(mk_special(6'b010010, 32'd0, 32'd0));
        check_val("div_lo", 76'(ex_wdata), 76'(32'hFFFFFFFD));
        run_instr(mk_special(6'b010000, 32'd0, 32'd0));
        check_val("div_hi", 76'(ex_wdata), 76'(32'hFFFFFFFF));
        // MULTU back-to-back with MFHI/MFLO
        run_instr(mk_special(6'b011001, 32'hFFFFFFFF, 32'd2));
        run_instr(mk_special(6'b010000, 32'd0, 32'd0));
        check_val("multu_hi", 76'(ex_wdata), 76'd1);
        run_instr(mk_special(6'b010010, 32'd0, 32'd0));
        check_val("multu_lo", 76'(ex_wdata), 76'(32'hFFFFFFFE));
        // DIVU by zero
        run_instr(mk_special(6'b011011, 32'd9, 32'd0));
        run_instr(mk_special(6'b010010, 32'd0, 32'd0));
        check_val("divz_lo", 76'(ex_wdata), 76'(32'hFFFFFFFF));
        run_instr(mk_special(6'b010000, 32'd0, 32'd0));
        check_val("divz_hi", 76'(ex_wdata), 76'd9);

        // Reset in the middle of a divide at RUN count 10
        run_instr(mk_special(6'b011000, 32'h0001_2345, 32'h0006_789A));
        t = mk_special(6'b011010, 32'd1000, 32'd7);
        step(t, 6'd0);
        repeat (11) step(t, 6'b001111);
        check_val("mid_div_stallreq", 76'(stallreq_for_ex), 76'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_div_stallreq", 76'(stallreq_for_ex), 76'd0);
        check_val("rst_div_bus", ex_to_mem_bus, 76'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        stall = 6'd0;
        id_to_ex_bus = '0;
        run_instr(mk_special(6'b010000, 32'd0, 32'd0));
        run_instr(mk_special(6'b010010, 32'd0, 32'd0));

        // Random mix against the model
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                5: begin
                    inst = $urandom;
                    inst[31:26] = $urandom_range(0, 1) ? 6'b100011 : 6'b101011;
                    t = mk_alu(inst, 12'h001, 3'b001, 4'b0010, rand_word(), rand_word());
                    t.ram_en = 1'b1;
                    t.ram_wen = inst[26] ? 4'hF : 4'h0;
                    t.rf_we = ~inst[26];
                    t.sel_rf_res = ~inst[26];
                end
                6: t = mk_special($urandom_range(0, 1) ? 6'b011000 : 6'b011001, rand_word(), rand_word());
                7: t = mk_special($urandom_range(0, 1) ? 6'b010000 : 6'b010010, 32'd0, 32'd0);
                8: t = mk_special($urandom_range(0, 1) ? 6'b010001 : 6'b010011, rand_word(), 32'd0);
                9: begin
                    case ($urandom_range(0, 3))
                        0:       t = mk_special(6'b011010, rand_word(), 32'd0);
                        1:       t = mk_special(6'b011011, rand_word(), 32'($urandom_range(1, 15)));
                        2:       t = mk_special(6'b011010, rand_word(), 32'hFFFFFFFF);
                        default: t = mk_special($urandom_range(0, 1) ? 6'b011010 : 6'b011011, rand_word(), rand_word());
                    endcase
                end
                default: begin
                    inst = $urandom;
                    if (inst[31:26] == 6'd0) inst[31:26] = 6'b001000;
                    t = mk_alu(inst, 12'd1 << $urandom_range(0, 11), 3'd1 << $urandom_range(0, 2),
                               4'd1 << $urandom_range(0, 3), rand_word(), rand_word());
                    t.rf_we = 1'($urandom_range(0, 1));
                end
            endcase
            run_instr(t);
        end
        run_instr(mk_special(6'b010000, 32'd0, 32'd0));
        run_instr(mk_special(6'b010010, 32'd0, 32'd0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
